key_beep_ctrl: RTL and testbench
================================

Name: key_beep_ctrl

Overview:
Controller between the key debouncer and the piezo buzzer. It consumes the debouncer's periodic key_flag/key_value samples and classifies each press as short or long. It then sequences the buzzer: one beep for a short press, two beeps for a long press. A one-deep pending slot lets a request raised during an active sequence play afterwards; further requests are dropped and reported.

Parameters:
TONE_HALF, 12_500, clock cycles per half-period of the buzzer square wave (2 kHz at 50 MHz)
BEEP_CYC, 5_000_000, clock cycles the tone is driven per beep (100 ms)
GAP_CYC, 5_000_000, silent cycles after every beep (100 ms)
LONG_CYC, 50_000_000, cycles the key must stay held to count as a long press (1 s)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_flag  in  1  debouncer sample strobe, 1 cycle; repeats periodically while the key is stable
key_value  in  1  debounced level valid when key_flag=1; 0 = pressed, 1 = released
mute  in  1  1 forces beep low; sequencing timing is unchanged
beep  out  1  buzzer drive square wave
busy  out  1  high while a beep sequence is active (not IDLE)
short_evt  out  1  1-cycle pulse when a short press is classified
long_evt  out  1  1-cycle pulse when a long press is classified
drop  out  1  1-cycle pulse when a request is discarded

Behaviour:
- Interface: one clock, clk. rst_n is asynchronous and active-low. All outputs and state are registered on posedge clk.
- Reset values:
  - beep=0, busy=0, short_evt=0, long_evt=0, drop=0.
  - held=1 (accepted key level), hold_cnt=0, long_done=0, pending=0, state=IDLE.
- Reset asserted mid-sequence aborts immediately to the reset values. No beep resumes after release.
- Key tracking (key_value is considered only when key_flag=1):
  - Press: key_flag=1, key_value=0, held=1. Set held=0, clear hold_cnt and long_done.
  - Release: key_flag=1, key_value=1, held=0. Set held=1.
    - If long_done=0, short_evt pulses high in the next cycle.
    - If long_done=1, no event.
  - Repeated flags with an unchanged level have no effect.
- Hold counter:
  - While held=0, hold_cnt increments every cycle and saturates at LONG_CYC.
  - When it reaches LONG_CYC with long_done=0: long_evt pulses for 1 cycle and long_done is set. The long event fires while the key is still held.
- Requests: short_evt requests 1 beep; long_evt requests 2 beeps.
- FSM states: IDLE, TONE, GAP. Registers: rem (beeps remaining, 2 bits), tcnt (phase counter), hcnt (half-period counter).
- IDLE:
  - A request (evt high this cycle) moves the FSM to TONE at the next edge, with rem=N-1, tcnt=0, hcnt=0, and beep=1 unless mute.
  - Else, if pending≠0, load pending the same way and clear pending.
- TONE:
  - Lasts exactly BEEP_CYC cycles.
  - beep toggles each time hcnt reaches TONE_HALF-1; hcnt then wraps to 0.
  - Leaves for GAP after BEEP_CYC cycles; beep=0 throughout GAP.
- GAP:
  - Lasts exactly GAP_CYC cycles.
  - Then goes to TONE if rem>0 (rem decrements, counters clear), else IDLE.
- Total busy time per sequence: N×(BEEP_CYC+GAP_CYC) cycles.
- Requests while busy:
  - If pending=0, store the count in pending.
  - If pending≠0, discard the request and pulse drop.
  - Pending is served from IDLE the cycle after the sequence ends, with no extra gap.
- mute: beep=0 whenever mute=1. Counters, busy and rem behave identically.
- Counter widths are $clog2(param+1), so no wrap occurs before the terminal count.

Test Plan (bench parameters: TONE_HALF=2, BEEP_CYC=20, GAP_CYC=10, LONG_CYC=100):
1. Reset → all outputs 0. Pulse release flags (value=1) while idle → no event.
2. Short press: press flag, 30 cycles, release flag → short_evt one cycle after release. busy high 30 cycles. beep toggles every 2 cycles for 20 cycles, then low 10.
3. Long press: press flag and hold 150 cycles → long_evt exactly 100 cycles after press flag. busy 60 cycles with two 20-cycle tones. Later release → no short_evt.
4. Queueing: short press at t=0, then two more short presses during TONE → first stored as pending (second tone burst starts immediately after first GAP). Second press → drop pulse, no third burst.
5. mute=1 during a long-press sequence → beep stays 0, busy still 60 cycles, rem sequencing unchanged.
6. Assert rst_n=0 mid-TONE → beep, busy, pending cleared asynchronously. After deassert, no residual beep until the next press.

Source files
------------

// File: rtl/key_beep_ctrl.sv
// rtl/key_beep_ctrl.sv - key press classifier and buzzer beep sequencer
module key_beep_ctrl #(
  parameter int TONE_HALF = 12_500,
  parameter int BEEP_CYC  = 5_000_000,
  parameter int GAP_CYC   = 5_000_000,
  parameter int LONG_CYC  = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_flag,
  input  logic key_value,
  input  logic mute,
  output logic beep,
  output logic busy,
  output logic short_evt,
  output logic long_evt,
  output logic drop
);

  localparam int PH_MAX = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
  localparam int HW = $clog2(TONE_HALF + 1);
  localparam int TW = $clog2(PH_MAX + 1);
  localparam int LW = $clog2(LONG_CYC + 1);

  localparam logic [HW-1:0] HALF_LAST = HW'(TONE_HALF - 1);
  localparam logic [TW-1:0] BEEP_LAST = TW'(BEEP_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYC);
  localparam logic [LW-1:0] LONG_PRE  = LW'(LONG_CYC - 1);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_e;

  state_e          state_q, state_d;
  logic            held_q, held_d;
  logic [LW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            long_done_q, long_done_d;
  logic            short_q, short_d;
  logic            long_q, long_d;
  logic            drop_q, drop_d;
  logic [1:0]      pending_q, pending_d;
  logic [1:0]      rem_q, rem_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic            phase_q, phase_d;
  logic            beep_q, beep_d;
  logic [1:0]      req_n, load_n;
  logic            press, release_k;

  assign press     = key_flag & ~key_value & held_q;
  assign release_k = key_flag &  key_value & ~held_q;

  // A release on the very cycle the hold count matures wins: it is a short press.
  always_comb begin
    held_d      = held_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    short_d     = 1'b0;
    long_d      = 1'b0;
    if (press) begin
      held_d      = 1'b0;
      hold_cnt_d  = '0;
      long_done_d = 1'b0;
    end else if (release_k) begin
      held_d  = 1'b1;
      short_d = ~long_done_q;
    end else if (!held_q) begin
      if (hold_cnt_q != LONG_MAX) hold_cnt_d = hold_cnt_q + LW'(1);
      if (!long_done_q && hold_cnt_q == LONG_PRE) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end
  end

  always_comb begin
    req_n     = short_q ? 2'd1 : (long_q ? 2'd2 : 2'd0);
    load_n    = 2'd0;
    state_d   = state_q;
    rem_d     = rem_q;
    tcnt_d    = tcnt_q;
    hcnt_d    = hcnt_q;
    phase_d   = phase_q;
    pending_d = pending_q;
    drop_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_n != 2'd0) begin
          load_n = req_n;
        end else if (pending_q != 2'd0) begin
          load_n    = pending_q;
          pending_d = 2'd0;
        end
      end
      TONE: begin
        if (tcnt_q == BEEP_LAST) begin
          state_d = GAP;
          tcnt_d  = '0;
          phase_d = 1'b0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (hcnt_q == HALF_LAST) begin
            hcnt_d  = '0;
            phase_d = ~phase_q;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
      end
      GAP: begin
        if (tcnt_q == GAP_LAST) begin
          tcnt_d = '0;
          if (rem_q != 2'd0) begin
            state_d = TONE;
            rem_d   = rem_q - 2'd1;
            hcnt_d  = '0;
            phase_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_n != 2'd0) begin
      state_d = TONE;
      rem_d   = load_n - 2'd1;
      tcnt_d  = '0;
      hcnt_d  = '0;
      phase_d = 1'b1;
    end
    if (state_q != IDLE && req_n != 2'd0) begin
      if (pending_q == 2'd0) pending_d = req_n;
      else                   drop_d    = 1'b1;
    end
    // Phase keeps running under mute so unmuting mid-tone stays in step.
    beep_d = (state_d == TONE) & phase_d & ~mute;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      held_q      <= 1'b1;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      drop_q      <= 1'b0;
      pending_q   <= 2'd0;
      rem_q       <= 2'd0;
      tcnt_q      <= '0;
      hcnt_q      <= '0;
      phase_q     <= 1'b0;
      beep_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      short_q     <= short_d;
      long_q      <= long_d;
      drop_q      <= drop_d;
      pending_q   <= pending_d;
      rem_q       <= rem_d;
      tcnt_q      <= tcnt_d;
      hcnt_q      <= hcnt_d;
      phase_q     <= phase_d;
      beep_q      <= beep_d;
    end
  end

  assign beep      = beep_q;
  assign busy      = (state_q != IDLE);
  assign short_evt = short_q;
  assign long_evt  = long_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_key_beep_ctrl.sv
// tb/tb_key_beep_ctrl.sv - randomized and directed bench for key_beep_ctrl
module tb_key_beep_ctrl;

  localparam int H = 2;
  localparam int B = 20;
  localparam int G = 10;
  localparam int L = 100;
  localparam int P = B + G;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_flag = 1'b0;
  logic key_value = 1'b1;
  logic mute = 1'b0;
  logic beep, busy, short_evt, long_evt, drop;
  logic [4:0] outs;

  assign outs = {beep, busy, short_evt, long_evt, drop};

  key_beep_ctrl #(.TONE_HALF(H), .BEEP_CYC(B), .GAP_CYC(G), .LONG_CYC(L)) dut (
    .clk(clk), .rst_n(rst_n), .key_flag(key_flag), .key_value(key_value), .mute(mute),
    .beep(beep), .busy(busy), .short_evt(short_evt), .long_evt(long_evt), .drop(drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: keys tracked by press time, sequences by start edge and length.
  int e = 0;
  bit m_held = 1'b1;
  int m_press_edge = 0;
  bit m_long_done = 1'b0;
  bit m_prev_short = 1'b0;
  bit m_prev_long = 1'b0;
  bit seq_valid = 1'b0;
  int seq_start = 0;
  int seq_n = 0;
  int m_pending = 0;
  logic [4:0] exp_outs = 5'd0;

  task automatic model_reset();
    m_held = 1'b1; m_long_done = 1'b0; m_prev_short = 1'b0; m_prev_long = 1'b0;
    seq_valid = 1'b0; m_pending = 0; exp_outs = 5'd0;
  endtask

  task automatic model_edge(input bit kf, input bit kv, input bit mu);
    int req, off, k;
    bit busy_prev, s, l, d, eb, ebusy;
    e++;
    req = m_prev_short ? 1 : (m_prev_long ? 2 : 0);
    busy_prev = seq_valid && ((e - 1 - seq_start) < seq_n * P);
    s = 1'b0; l = 1'b0; d = 1'b0;
    if (kf && !kv && m_held) begin
      m_held = 1'b0; m_press_edge = e; m_long_done = 1'b0;
    end else if (kf && kv && !m_held) begin
      m_held = 1'b1; s = !m_long_done;
    end else if (!m_held && !m_long_done && e == m_press_edge + L) begin
      l = 1'b1; m_long_done = 1'b1;
    end
    if (!busy_prev) begin
      if (req != 0) begin
        seq_valid = 1'b1; seq_start = e; seq_n = req;
      end else if (m_pending != 0) begin
        seq_valid = 1'b1; seq_start = e; seq_n = m_pending; m_pending = 0;
      end
    end else if (req != 0) begin
      if (m_pending == 0) m_pending = req;
      else d = 1'b1;
    end
    off = e - seq_start;
    ebusy = seq_valid && off < seq_n * P;
    k = off % P;
    eb = ebusy && (k < B) && ((k / H) % 2 == 0) && !mu;
    exp_outs = {eb, ebusy, s, l, d};
    m_prev_short = s;
    m_prev_long = l;
  endtask

  int cnt_busy, cnt_beep, cnt_short, cnt_long, cnt_drop, long_edge;
  string phase_tag = "init";

  task automatic clr_cnt();
    cnt_busy = 0; cnt_beep = 0; cnt_short = 0; cnt_long = 0; cnt_drop = 0; long_edge = -1;
  endtask

  task automatic tick(input bit kf, input bit kv);
    @(negedge clk);
    key_flag = kf;
    key_value = kv;
    @(posedge clk);
    model_edge(kf, kv, mute);
    #1;
    chk(phase_tag, int'(outs), int'(exp_outs));
    cnt_busy += int'(busy);
    cnt_beep += int'(beep);
    cnt_short += int'(short_evt);
    cnt_drop += int'(drop);
    if (long_evt) begin
      cnt_long++;
      long_edge = e;
    end
  endtask

  // Idle cycles; a flag repeating the current level every 8 cycles must be ignored.
  task automatic hold(input int n, input bit lv);
    for (int i = 0; i < n; i++) tick((i % 8) == 7, lv);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk("rst_async", int'(outs), 0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_hold", int'(outs), 0);
    end
    key_flag = 1'b0;
    rst_n = 1'b1;
  endtask

  int pe;
  bit lv;
  int dur;

  initial begin
    clr_cnt();
    #1 chk("reset_outs", int'(outs), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    phase_tag = "idle_release";
    clr_cnt();
    for (int i = 0; i < 4; i++) begin tick(1, 1); hold(3, 1); end
    chk("idle_no_evt", cnt_short + cnt_long + cnt_busy, 0);

    phase_tag = "short";
    clr_cnt();
    tick(1, 0); hold(30, 0); tick(1, 1); hold(40, 1);
    chk("short_cnt", cnt_short, 1);
    chk("short_busy", cnt_busy, 30);
    chk("short_beep", cnt_beep, 10);

    phase_tag = "long";
    clr_cnt();
    tick(1, 0); pe = e; hold(150, 0); tick(1, 1); hold(80, 1);
    chk("long_cnt", cnt_long, 1);
    chk("long_delay", long_edge - pe, L);
    chk("long_no_short", cnt_short, 0);
    chk("long_busy", cnt_busy, 60);
    chk("long_beep", cnt_beep, 20);

    phase_tag = "queue";
    clr_cnt();
    tick(1, 0); hold(2, 0); tick(1, 1); hold(4, 1);
    tick(1, 0); hold(1, 0); tick(1, 1); hold(2, 1);
    tick(1, 0); hold(1, 0); tick(1, 1); hold(80, 1);
    chk("queue_short", cnt_short, 3);
    chk("queue_drop", cnt_drop, 1);
    chk("queue_busy", cnt_busy, 60);
    chk("queue_beep", cnt_beep, 20);

    phase_tag = "mute";
    clr_cnt();
    mute = 1'b1;
    tick(1, 0); hold(150, 0); tick(1, 1); hold(80, 1);
    mute = 1'b0;
    chk("mute_beep", cnt_beep, 0);
    chk("mute_busy", cnt_busy, 60);
    chk("mute_long", cnt_long, 1);

    phase_tag = "reset_mid";
    clr_cnt();
    tick(1, 0); hold(2, 0); tick(1, 1); hold(6, 1);
    chk("pre_rst_busy", int'(busy), 1);
    do_reset();
    clr_cnt();
    phase_tag = "after_rst";
    hold(50, 1);
    chk("post_rst_beep", cnt_beep, 0);
    chk("post_rst_busy", cnt_busy, 0);

    phase_tag = "random";
    lv = 1'b1;
    for (int seg = 0; seg < 45; seg++) begin
      dur = $urandom_range(3, 180);
      for (int i = 0; i < dur; i++) begin
        if ($urandom_range(0, 99) == 0) mute = ~mute;
        tick($urandom_range(0, 3) == 0, lv);
      end
      lv = ~lv;
    end
    hold(200, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
